cci_mpf_mem_responder: RTL and testbench



---
 rtl/cci_mpf_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_cci_mpf_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_mem_responder.sv
// cci_mpf_mem_responder: memory-side responder for MPF C0/C1 TX requests
//
// Accepts C0 read and C1 write requests, queues each channel in its own
// FIFO, and services one request per cycle from a line-addressed memory.
// Each response comes back as a CCI RX response after a fixed pipeline
// delay.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   c0Tx / c1Tx           MPF read / write+interrupt requests
//   c0TxAlmFull/c1TxAlmFull  registered FIFO almost-full
//   c0Rx / c1Rx           read responses / write acks, no backpressure
//   errSticky             {intr drop, virtual-address drop, overflow drop}
package cci_mpf_if_pkg;
  localparam int CCI_ALMOST_FULL_THRESHOLD = 2;
  typedef logic [41:0] t_cci_clAddr;
  typedef logic [15:0] t_cci_mdata;
  typedef logic [511:0] t_cci_clData;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_WRLINE = 4'h1} t_cci_rsp;
  typedef struct packed {
    logic addrIsVirtual;
    t_cci_mdata mdata;
    t_cci_clAddr address;
  } t_cci_mpf_ReqMemHdr;
  typedef struct packed {
    t_cci_mpf_ReqMemHdr hdr;
    logic rdValid;
  } t_if_cci_mpf_c0_Tx;
  typedef struct packed {
    t_cci_mpf_ReqMemHdr hdr;
    t_cci_clData data;
    logic wrValid;
    logic intrValid;
  } t_if_cci_mpf_c1_Tx;
  typedef struct packed {
    t_cci_rsp respType;
    t_cci_mdata mdata;
  } t_cci_RspMemHdr;
  typedef struct packed {
    t_cci_RspMemHdr hdr;
    t_cci_clData data;
    logic rdValid;
  } t_if_cci_c0_Rx;
  typedef struct packed {
    t_cci_RspMemHdr hdr;
    logic wrValid;
  } t_if_cci_c1_Rx;
  function automatic logic cci_mpf_c0TxIsValid(t_if_cci_mpf_c0_Tx r);
    return r.rdValid;
  endfunction
  function automatic logic cci_mpf_getReqAddrIsVirtual(t_cci_mpf_ReqMemHdr h);
    return h.addrIsVirtual;
  endfunction
  function automatic t_cci_RspMemHdr cci_genRspHdr(t_cci_rsp t, t_cci_mdata m);
    return '{respType: t, mdata: m};
  endfunction
endpackage

module cci_mpf_mem_responder
  import cci_mpf_if_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int LATENCY = 4,
  parameter int MEM_LINES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  t_if_cci_mpf_c0_Tx c0Tx,
  input  t_if_cci_mpf_c1_Tx c1Tx,
  output logic              c0TxAlmFull,
  output logic              c1TxAlmFull,
  output t_if_cci_c0_Rx     c0Rx,
  output t_if_cci_c1_Rx     c1Rx,
  output logic [2:0]        errSticky
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);
  localparam logic [PW:0] QALM = (PW+1)'(QDEPTH - CCI_ALMOST_FULL_THRESHOLD);
  typedef logic [IW-1:0] t_idx;
  typedef struct packed {
    logic valid;
    logic isWr;
    t_cci_mdata mdata;
    t_cci_clData data;
  } t_slot;
  t_idx c0Idx [QDEPTH];
  t_cci_mdata c0Md [QDEPTH];
  t_idx c1Idx [QDEPTH];
  t_cci_mdata c1Md [QDEPTH];
  t_cci_clData c1Dat [QDEPTH];
  t_cci_clData mem [MEM_LINES];
  t_slot pipe [LATENCY+1];
  logic [PW:0] c0Wr, c0Rd, c1Wr, c1Rd, c0Occ, c1Occ, c0OccNext, c1OccNext;
  logic c0Virt, c1Virt, c0Full, c1Full, c0Enq, c1Enq, gnt0, gnt1, lastC1;
  logic unusedBits;
  t_idx rdLine, wrLine;
  assign unusedBits = ^{c0Tx.hdr.address[41:IW], c1Tx.hdr.address[41:IW]};
  always_comb begin
    c0Occ = c0Wr - c0Rd;
    c1Occ = c1Wr - c1Rd;
    c0Full = c0Occ == QFULL;
    c1Full = c1Occ == QFULL;
    c0Virt = cci_mpf_c0TxIsValid(c0Tx) && cci_mpf_getReqAddrIsVirtual(c0Tx.hdr);
    c1Virt = c1Tx.wrValid && cci_mpf_getReqAddrIsVirtual(c1Tx.hdr);
    c0Enq = cci_mpf_c0TxIsValid(c0Tx) && !c0Virt && !c0Full;
    c1Enq = c1Tx.wrValid && !c1Virt && !c1Full;
    // lastC1 set means C1 won the previous grant, so C0 wins a tie
    gnt0 = (c0Occ != '0) && ((c1Occ == '0) || lastC1);
    gnt1 = (c1Occ != '0) && !gnt0;
    c0OccNext = c0Occ + (PW+1)'(c0Enq) - (PW+1)'(gnt0);
    c1OccNext = c1Occ + (PW+1)'(c1Enq) - (PW+1)'(gnt1);
    rdLine = c0Idx[c0Rd[PW-1:0]];
    wrLine = c1Idx[c1Rd[PW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (c0Enq) begin
      c0Idx[c0Wr[PW-1:0]] <= c0Tx.hdr.address[IW-1:0];
      c0Md[c0Wr[PW-1:0]] <= c0Tx.hdr.mdata;
    end
    if (c1Enq) begin
      c1Idx[c1Wr[PW-1:0]] <= c1Tx.hdr.address[IW-1:0];
      c1Md[c1Wr[PW-1:0]] <= c1Tx.hdr.mdata;
      c1Dat[c1Wr[PW-1:0]] <= c1Tx.data;
    end
    if (gnt1) mem[wrLine] <= c1Dat[c1Rd[PW-1:0]];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0Wr <= '0;
      c0Rd <= '0;
      c1Wr <= '0;
      c1Rd <= '0;
      lastC1 <= 1'b1;
      c0TxAlmFull <= 1'b0;
      c1TxAlmFull <= 1'b0;
      errSticky <= '0;
      for (int i = 0; i <= LATENCY; i++) pipe[i] <= '0;
    end else begin
      c0Wr <= c0Wr + (PW+1)'(c0Enq);
      c1Wr <= c1Wr + (PW+1)'(c1Enq);
      c0Rd <= c0Rd + (PW+1)'(gnt0);
      c1Rd <= c1Rd + (PW+1)'(gnt1);
      if (gnt0 || gnt1) lastC1 <= gnt1;
      c0TxAlmFull <= c0OccNext >= QALM;
      c1TxAlmFull <= c1OccNext >= QALM;
      errSticky <= errSticky | {c1Tx.intrValid, c0Virt || c1Virt,
                                (cci_mpf_c0TxIsValid(c0Tx) && c0Full) || (c1Tx.wrValid && c1Full)};
      // stage 0 is the memory access itself; LATENCY stages follow it
      pipe[0] <= '{valid: gnt0 || gnt1, isWr: gnt1,
                   mdata: gnt1 ? c1Md[c1Rd[PW-1:0]] : c0Md[c0Rd[PW-1:0]],
                   data: mem[rdLine]};
      for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_comb begin
    c0Rx.hdr = cci_genRspHdr(eRSP_RDLINE, pipe[LATENCY].mdata);
    c0Rx.data = pipe[LATENCY].data;
    c0Rx.rdValid = pipe[LATENCY].valid && !pipe[LATENCY].isWr;
    c1Rx.hdr = cci_genRspHdr(eRSP_WRLINE, pipe[LATENCY].mdata);
    c1Rx.wrValid = pipe[LATENCY].valid && pipe[LATENCY].isWr;
  end
endmodule

// File: tb/tb_cci_mpf_mem_responder.sv
// tb_cci_mpf_mem_responder: randomized bench with a transaction-level reference model
module tb_cci_mpf_mem_responder;
  import cci_mpf_if_pkg::*;
  localparam int LAT = 4;
  localparam int QD = 8;
  localparam int ML = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  t_if_cci_mpf_c0_Tx c0Tx;
  t_if_cci_mpf_c1_Tx c1Tx;
  logic c0TxAlmFull, c1TxAlmFull;
  t_if_cci_c0_Rx c0Rx;
  t_if_cci_c1_Rx c1Rx;
  logic [2:0] errSticky;
  cci_mpf_mem_responder #(.QDEPTH(QD), .LATENCY(LAT), .MEM_LINES(ML)) dut (
    .clk(clk), .reset(reset), .c0Tx(c0Tx), .c1Tx(c1Tx),
    .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
    .c0Rx(c0Rx), .c1Rx(c1Rx), .errSticky(errSticky)
  );
  always #5 clk = ~clk;
  typedef struct {
    int idx;
    logic [15:0] md;
    logic [511:0] data;
  } req_t;
  typedef struct {
    int t;
    bit wr;
    logic [15:0] md;
    logic [511:0] data;
    bit known;
  } rsp_t;
  req_t q0[$];
  req_t q1[$];
  rsp_t pend[$];
  logic [511:0] mMem [ML];
  bit known [ML];
  bit favC1;
  logic [2:0] mErr;
  int edgeN, accepted, rdSeen, wrSeen, checks, failures;
  bit almSeen;
  logic [511:0] lastRdData;
  logic [15:0] lastRdMd;
  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  task automatic idle();
    c0Tx = '0;
    c1Tx = '0;
  endtask
  task automatic rd(logic [41:0] a, logic [15:0] m, logic v);
    c0Tx.rdValid = 1'b1;
    c0Tx.hdr.address = a;
    c0Tx.hdr.mdata = m;
    c0Tx.hdr.addrIsVirtual = v;
  endtask
  task automatic wr(logic [41:0] a, logic [15:0] m, logic [511:0] d);
    c1Tx.wrValid = 1'b1;
    c1Tx.hdr.address = a;
    c1Tx.hdr.mdata = m;
    c1Tx.hdr.addrIsVirtual = 1'b0;
    c1Tx.data = d;
  endtask
  // One clock edge: advance the reference model with the inputs that were
  // sampled at this edge, then compare every DUT output against it.
  task automatic step();
    rsp_t e;
    req_t r;
    bit have;
    int s0, s1;
    @(posedge clk);
    #1;
    edgeN++;
    if (reset) begin
      q0.delete();
      q1.delete();
      pend.delete();
      favC1 = 1'b0;
      mErr = '0;
    end else begin
      s0 = q0.size();
      s1 = q1.size();
      if (s0 > 0 && (s1 == 0 || !favC1)) begin
        r = q0.pop_front();
        pend.push_back('{edgeN + LAT, 1'b0, r.md, mMem[r.idx], known[r.idx]});
        favC1 = 1'b1;
      end else if (s1 > 0) begin
        r = q1.pop_front();
        mMem[r.idx] = r.data;
        known[r.idx] = 1'b1;
        pend.push_back('{edgeN + LAT, 1'b1, r.md, '0, 1'b1});
        favC1 = 1'b0;
      end
      if (c0Tx.rdValid) begin
        if (c0Tx.hdr.addrIsVirtual) mErr[1] = 1'b1;
        if (s0 == QD) mErr[0] = 1'b1;
        if (!c0Tx.hdr.addrIsVirtual && s0 != QD) begin
          q0.push_back('{int'(c0Tx.hdr.address % ML), c0Tx.hdr.mdata, '0});
          accepted++;
        end
      end
      if (c1Tx.wrValid) begin
        if (c1Tx.hdr.addrIsVirtual) mErr[1] = 1'b1;
        if (s1 == QD) mErr[0] = 1'b1;
        if (!c1Tx.hdr.addrIsVirtual && s1 != QD) begin
          q1.push_back('{int'(c1Tx.hdr.address % ML), c1Tx.hdr.mdata, c1Tx.data});
          accepted++;
        end
      end
      if (c1Tx.intrValid) mErr[2] = 1'b1;
    end
    have = pend.size() > 0 && pend[0].t == edgeN;
    if (have) e = pend.pop_front();
    chk("rdValid", 512'(c0Rx.rdValid), 512'(have && !e.wr));
    chk("wrValid", 512'(c1Rx.wrValid), 512'(have && e.wr));
    if (have && !e.wr) begin
      chk("rdMdata", 512'(c0Rx.hdr.mdata), 512'(e.md));
      chk("rdType", 512'(c0Rx.hdr.respType), 512'(eRSP_RDLINE));
      if (e.known) chk("rdData", c0Rx.data, e.data);
    end
    if (have && e.wr) begin
      chk("wrMdata", 512'(c1Rx.hdr.mdata), 512'(e.md));
      chk("wrType", 512'(c1Rx.hdr.respType), 512'(eRSP_WRLINE));
    end
    chk("c0AlmFull", 512'(c0TxAlmFull), 512'(q0.size() >= QD - CCI_ALMOST_FULL_THRESHOLD));
    chk("c1AlmFull", 512'(c1TxAlmFull), 512'(q1.size() >= QD - CCI_ALMOST_FULL_THRESHOLD));
    chk("errSticky", 512'(errSticky), 512'(mErr));
    if (c0TxAlmFull || c1TxAlmFull) almSeen = 1'b1;
    if (c0Rx.rdValid) begin
      rdSeen++;
      lastRdData = c0Rx.data;
      lastRdMd = c0Rx.hdr.mdata;
    end
    if (c1Rx.wrValid) wrSeen++;
  endtask
  initial begin
    int base, acc0;
    logic [511:0] d;
    checks = 0;
    failures = 0;
    idle();
    reset = 1'b1;
    step();
    step();
    chk("resetErr", 512'(errSticky), 512'(3'b000));
    chk("resetAlm", 512'({c0TxAlmFull, c1TxAlmFull}), 512'(2'b00));
    reset = 1'b0;
    // write then read the same line on consecutive cycles
    wr({$urandom, 2'b00, 8'h05}, 16'h0011, {64{8'hA5}});
    step();
    idle();
    rd({$urandom, 2'b00, 8'h05}, 16'h0022, 1'b0);
    step();
    idle();
    repeat (3) step();
    step();
    chk("ackAt5", 512'({c1Rx.wrValid, c1Rx.hdr.mdata}), 512'({1'b1, 16'h0011}));
    step();
    chk("rdAfterWr", 512'({c0Rx.rdValid, c0Rx.hdr.mdata}), 512'({1'b1, 16'h0022}));
    chk("rdAfterWrData", c0Rx.data, {64{8'hA5}});
    chk("wtrErr", 512'(errSticky), 512'(3'b000));
    // back-to-back reads of freshly written lines
    for (int i = 0; i < 8; i++) begin
      wr(42'(16 + i * 7), 16'(16'h0200 + i), rnd512());
      step();
    end
    idle();
    repeat (8) step();
    base = rdSeen;
    for (int i = 0; i < 8; i++) begin
      rd(42'(16 + i * 7), 16'(16'h0100 + i), 1'b0);
      step();
    end
    idle();
    repeat (12) step();
    chk("b2bCount", 512'(rdSeen - base), 512'(8));
    // sustained dual-channel load with overflow
    acc0 = accepted;
    base = rdSeen + wrSeen;
    almSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd(42'({$urandom, $urandom}), 16'($urandom), 1'b0);
      wr(42'({$urandom, $urandom}), 16'($urandom), rnd512());
      step();
    end
    idle();
    repeat (40) step();
    chk("arbRspCount", 512'(rdSeen + wrSeen - base), 512'(accepted - acc0));
    chk("arbOverflow", 512'(errSticky[0]), 512'(1'b1));
    chk("arbAlmSeen", 512'(almSeen), 512'(1'b1));
    // illegal requests
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = rdSeen + wrSeen;
    rd(42'($urandom), 16'h0033, 1'b1);
    step();
    idle();
    c1Tx.intrValid = 1'b1;
    step();
    idle();
    repeat (10) step();
    chk("illegalNoRsp", 512'(rdSeen + wrSeen - base), 512'(0));
    chk("illegalErr", 512'(errSticky), 512'(3'b110));
    // reset while reads are in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    d = rnd512();
    wr(42'h33, 16'h0044, d);
    step();
    idle();
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      rd(42'h33, 16'(16'h0050 + i), 1'b0);
      step();
    end
    idle();
    step();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    base = rdSeen;
    repeat (10) step();
    chk("noRspAfterReset", 512'(rdSeen - base), 512'(0));
    rd(42'h33, 16'h0077, 1'b0);
    step();
    idle();
    repeat (6) step();
    chk("postResetRdCount", 512'(rdSeen - base), 512'(1));
    chk("postResetMd", 512'(lastRdMd), 512'(16'h0077));
    chk("postResetData", lastRdData, d);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
